// File: rtl/write_buffer.sv
// Block write buffer between cache miss/writeback port and memory.
// Queues dirty blocks, drains in background, lets read misses bypass.
module write_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter int BLOCK_W  = 128,
  parameter int OFFSET_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               up_valid,
  input  logic               up_write,
  input  logic [ADDR_W-1:0]  up_addr,
  input  logic [BLOCK_W-1:0] up_wdata,
  output logic               up_ready,
  output logic [BLOCK_W-1:0] up_rdata,
  output logic               mem_valid,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic               wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    U_IDLE, U_STALL, U_WAITMEM, U_RESP
  } ustate_t;

  typedef enum logic [1:0] {
    M_IDLE, M_READ, M_WRITE, M_GAP
  } mstate_t;

  logic [TAG_W-1:0]   r_tag  [DEPTH];
  logic [BLOCK_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  ustate_t r_us;
  mstate_t r_ms;
  logic    r_rd_pend;

  logic [TAG_W-1:0] w_tag;
  logic             w_head_busy;
  logic             w_full;
  logic             w_rd_hit;
  logic             w_wr_hit;
  logic [PTR_W-1:0] w_rd_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_idx;
  logic             w_take;
  logic             w_enq;
  logic             w_ovw;
  logic             w_pop;
  logic             w_rd_done;

  assign w_tag  = up_addr[ADDR_W-1:OFFSET_W];
  assign w_full = (r_count == CNT_W'(DEPTH));

  // The head is also treated as in flight in the cycle the drain launches,
  // because its data is captured into mem_wdata on that edge.
  assign w_head_busy = (r_ms == M_WRITE) ||
                       (r_ms == M_IDLE && !r_rd_pend && r_count != '0);

  assign w_take    = (r_us == U_IDLE) && up_valid;
  assign w_ovw     = w_take && up_write && w_wr_hit;
  assign w_enq     = (w_take && up_write && !w_wr_hit && !w_full) ||
                     (r_us == U_STALL && !w_full);
  assign w_pop     = (r_ms == M_WRITE) && mem_ready;
  assign w_rd_done = (r_ms == M_READ) && mem_ready;

  assign wb_empty = (r_count == '0) && (r_ms != M_WRITE);

  // Address match, scanned oldest to youngest so the last hit wins.
  always_comb begin
    w_rd_hit = 1'b0;
    w_wr_hit = 1'b0;
    w_rd_idx = '0;
    w_wr_idx = '0;
    w_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count && r_tag[w_idx] == w_tag) begin
        w_rd_hit = 1'b1;
        w_rd_idx = w_idx;
        if (!(k == 0 && w_head_busy)) begin
          w_wr_hit = 1'b1;
          w_wr_idx = w_idx;
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_pop) r_head <= r_head + PTR_W'(1);
      unique case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: allocate at tail or coalesce into a queued entry.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_tag[r_tail]  <= w_tag;
      r_data[r_tail] <= up_wdata;
    end
    if (w_ovw) begin
      r_data[w_wr_idx] <= up_wdata;
    end
  end

  // Upstream request FSM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_us      <= U_IDLE;
      up_ready  <= 1'b0;
      up_rdata  <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      up_ready <= 1'b0;
      case (r_us)
        U_IDLE: begin
          if (up_valid) begin
            if (up_write) begin
              if (w_wr_hit || !w_full) begin
                r_us     <= U_RESP;
                up_ready <= 1'b1;
              end else begin
                r_us <= U_STALL;
              end
            end else if (w_rd_hit) begin
              up_rdata <= r_data[w_rd_idx];
              r_us     <= U_RESP;
              up_ready <= 1'b1;
            end else begin
              r_rd_pend <= 1'b1;
              r_us      <= U_WAITMEM;
            end
          end
        end
        U_STALL: begin
          if (!w_full) begin
            r_us     <= U_RESP;
            up_ready <= 1'b1;
          end
        end
        U_WAITMEM: begin
          if (w_rd_done) begin
            up_rdata  <= mem_rdata;
            r_rd_pend <= 1'b0;
            r_us      <= U_RESP;
            up_ready  <= 1'b1;
          end
        end
        default: r_us <= U_IDLE;
      endcase
    end
  end

  // Memory FSM: read misses first, otherwise drain the head entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ms      <= M_IDLE;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_ms)
        M_IDLE: begin
          if (r_rd_pend) begin
            r_ms      <= M_READ;
            mem_valid <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= up_addr;
          end else if (r_count != '0) begin
            r_ms      <= M_WRITE;
            mem_valid <= 1'b1;
            mem_write <= 1'b1;
            mem_addr  <= {r_tag[r_head], {OFFSET_W{1'b0}}};
            mem_wdata <= r_data[r_head];
          end
        end
        M_READ, M_WRITE: begin
          if (mem_ready) begin
            r_ms      <= M_GAP;
            mem_valid <= 1'b0;
          end
        end
        default: r_ms <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: memory-consistency reference model,
// protocol monitor, directed scenarios and random traffic.
module tb_write_buffer;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         up_valid = 1'b0;
  logic         up_write = 1'b0;
  logic [31:0]  up_addr = '0;
  logic [127:0] up_wdata = '0;
  logic         up_ready;
  logic [127:0] up_rdata;
  logic         mem_valid;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_rdata = '0;
  logic         wb_empty;

  write_buffer #(
    .DEPTH(4), .ADDR_W(32), .BLOCK_W(128), .OFFSET_W(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .up_valid(up_valid), .up_write(up_write),
    .up_addr(up_addr), .up_wdata(up_wdata),
    .up_ready(up_ready), .up_rdata(up_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_empty(wb_empty)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit           w;
    logic [31:0]  a;
    logic [127:0] d;
  } mtx_t;

  logic [127:0] mem_m [logic [27:0]];
  logic [127:0] arch  [logic [27:0]];
  mtx_t         mlog  [$];

  bit           mem_hold = 0;
  int           max_lat = 0;
  int           lat = 0;
  int           mcnt = 0;

  bit           txn_act = 0;
  bit           cur_w = 0;
  logic [31:0]  cur_a = '0;
  logic [127:0] cur_d = '0;
  int           ready_cnt = 0;
  int           ready_cyc = 0;
  int           last_mr_cyc = 0;
  int           cyc = 0;
  int           rd_mem_cnt = 0;
  int           mv_cnt = 0;
  logic [127:0] last_rdata = '0;

  bit           p_mv, p_mr, p_ur, p_mw, p_we;
  logic [31:0]  p_ma;
  logic [127:0] p_md;

  function automatic logic [127:0] init_val(input logic [27:0] b);
    return {b, 4'h5, ~b, 4'ha, b ^ 28'h1234567, 4'h3,
            28'hfedcba9 - b, 4'hc};
  endfunction

  function automatic logic [127:0] mval(input logic [27:0] b);
    return mem_m.exists(b) ? mem_m[b] : init_val(b);
  endfunction

  function automatic logic [127:0] aval(input logic [27:0] b);
    return arch.exists(b) ? arch[b] : init_val(b);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory responder: random latency, optional hold, logs every completion.
  initial begin
    mtx_t t;
    forever begin
      @(posedge CLK);
      #2;
      if (RST) begin
        mem_ready = 1'b0;
        mcnt = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_valid && !mem_hold) begin
        if (mcnt >= lat) begin
          mem_ready = 1'b1;
          mcnt = 0;
          lat = $urandom_range(0, max_lat);
          if (mem_write) mem_m[mem_addr[31:4]] = mem_wdata;
          else mem_rdata = mval(mem_addr[31:4]);
          t.w = mem_write;
          t.a = mem_addr;
          t.d = mem_wdata;
          mlog.push_back(t);
        end else begin
          mcnt++;
        end
      end
    end
  end

  // Per-cycle protocol and consistency checks.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      p_mv = 0; p_mr = 0; p_ur = 0; p_mw = 0; p_we = 1;
      p_ma = '0; p_md = '0;
    end else begin
      if (p_mv && !p_mr) begin
        chk("mem_valid_held", 128'(mem_valid), 128'(1));
        chk("mem_write_stable", 128'(mem_write), 128'(p_mw));
        chk("mem_addr_stable", 128'(mem_addr), 128'(p_ma));
        if (p_mw) chk("mem_wdata_stable", mem_wdata, p_md);
      end
      if (p_mr) chk("mem_gap", 128'(mem_valid), 128'(0));
      if (p_ur) begin
        chk("up_ready_pulse", 128'(up_ready), 128'(0));
        chk("up_valid_drop", 128'(up_valid), 128'(0));
      end
      if (mem_valid) mv_cnt++;
      if (mem_valid && !mem_write) rd_mem_cnt++;
      if (mem_ready) last_mr_cyc = cyc;
      if (up_ready) begin
        chk("up_ready_txn", 128'(txn_act), 128'(1));
        if (cur_w) arch[cur_a[31:4]] = cur_d;
        else chk("up_rdata", up_rdata, aval(cur_a[31:4]));
        last_rdata = up_rdata;
        ready_cyc = cyc;
        ready_cnt++;
      end
      if (wb_empty && !p_we) begin
        foreach (arch[k]) chk("drained_mem", mval(k), arch[k]);
      end
      p_mv = mem_valid; p_mr = mem_ready; p_ur = up_ready;
      p_mw = mem_write; p_ma = mem_addr; p_md = mem_wdata;
      p_we = wb_empty;
    end
  end

  task automatic do_req(input bit w, input logic [31:0] a,
                        input logic [127:0] d, input int rel,
                        output int k, output bit stalled);
    int start;
    start = ready_cnt;
    k = 0;
    stalled = 0;
    @(posedge CLK);
    #1;
    up_valid = 1; up_write = w; up_addr = a; up_wdata = d;
    cur_w = w; cur_a = a; cur_d = d; txn_act = 1;
    while (ready_cnt == start && k < 300) begin
      @(posedge CLK);
      k++;
      if (rel > 0 && k == rel) begin
        stalled = (ready_cnt == start);
        mem_hold = 0;
      end
    end
    chk("up_ready_seen", 128'(ready_cnt != start), 128'(1));
    #1;
    up_valid = 0; up_write = 0; txn_act = 0;
    if (rel > 0) mem_hold = 0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (!(wb_empty && !mem_valid && !txn_act) && k < 500) begin
      @(negedge CLK);
      k++;
    end
    repeat (3) @(negedge CLK);
    chk("drain_done", 128'(wb_empty), 128'(1));
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    arch.delete();
    foreach (mem_m[k]) arch[k] = mem_m[k];
  endtask

  initial begin
    int k, n, m0;
    bit st;
    logic [127:0] dd [5];

    #1 RST = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_up_ready", 128'(up_ready), 128'(0));
    chk("rst_up_rdata", up_rdata, 128'(0));
    chk("rst_mem_valid", 128'(mem_valid), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_wb_empty", 128'(wb_empty), 128'(1));
    @(posedge CLK);
    #1 RST = 0;

    // Single write drains to memory, then a one-cycle gap.
    max_lat = 0;
    n = mlog.size();
    do_req(1, 32'h100, {4{32'haaaa_0001}}, 0, k, st);
    chk("t2_ready_latency", 128'(k), 128'(2));
    k = 0;
    while (mlog.size() == n && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("t2_mem_seen", 128'(mlog.size()), 128'(n + 1));
    @(posedge CLK);
    #3;
    chk("t2_gap_valid", 128'(mem_valid), 128'(0));
    chk("t2_gap_empty", 128'(wb_empty), 128'(1));
    if (mlog.size() > n) begin
      chk("t2_mem_addr", 128'(mlog[n].a), 128'(32'h100));
      chk("t2_mem_data", mlog[n].d, {4{32'haaaa_0001}});
    end
    wait_empty();

    // Coalescing into a queued (not yet launched) entry.
    mem_hold = 1;
    n = mlog.size();
    do_req(1, 32'h000, {4{32'h2222_0000}}, 0, k, st);
    do_req(1, 32'h100, {4{32'h2222_000a}}, 0, k, st);
    do_req(1, 32'h104, {4{32'h2222_000b}}, 0, k, st);
    mem_hold = 0;
    wait_empty();
    chk("t3_write_count", 128'(mlog.size() - n), 128'(2));
    if (mlog.size() >= n + 2) begin
      chk("t3_first_addr", 128'(mlog[n].a), 128'(32'h000));
      chk("t3_coal_addr", 128'(mlog[n+1].a), 128'(32'h100));
      chk("t3_coal_data", mlog[n+1].d, {4{32'h2222_000b}});
    end

    // Read forwarded from the buffer, no memory read.
    mem_hold = 1;
    do_req(1, 32'h200, {4{32'hcccc_0c0c}}, 0, k, st);
    m0 = rd_mem_cnt;
    do_req(0, 32'h208, '0, 0, k, st);
    chk("t4_fwd_data", last_rdata, {4{32'hcccc_0c0c}});
    chk("t4_no_mem_read", 128'(rd_mem_cnt - m0), 128'(0));
    mem_hold = 0;
    wait_empty();

    // Full buffer: fifth write stalls until the first pop.
    mem_hold = 1;
    n = mlog.size();
    for (int i = 0; i < 5; i++) dd[i] = {4{32'ha5a5_0000 + 32'(i)}};
    for (int i = 0; i < 4; i++)
      do_req(1, 32'h600 + 32'(i) * 32'h10, dd[i], 0, k, st);
    do_req(1, 32'h640, dd[4], 10, k, st);
    chk("t5_stalled", 128'(st), 128'(1));
    chk("t5_ready_after_pop", 128'(ready_cyc - last_mr_cyc), 128'(2));
    wait_empty();
    chk("t5_count", 128'(mlog.size() - n), 128'(5));
    if (mlog.size() >= n + 5)
      for (int i = 0; i < 5; i++) chk("t5_fifo_order", mlog[n+i].d, dd[i]);

    // Read miss bypasses the second queued write.
    mem_hold = 1;
    max_lat = 2;
    n = mlog.size();
    do_req(1, 32'h400, {4{32'hdddd_0004}}, 0, k, st);
    do_req(1, 32'h500, {4{32'heeee_0005}}, 0, k, st);
    do_req(0, 32'h300, '0, 6, k, st);
    chk("t6_rdata", last_rdata, init_val(28'h0000030));
    wait_empty();
    chk("t6_count", 128'(mlog.size() - n), 128'(3));
    if (mlog.size() >= n + 3) begin
      chk("t6_order0", 128'({mlog[n].w, mlog[n].a}), 128'({1'b1, 32'h400}));
      chk("t6_order1", 128'({mlog[n+1].w, mlog[n+1].a}), 128'({1'b0, 32'h300}));
      chk("t6_order2", 128'({mlog[n+2].w, mlog[n+2].a}), 128'({1'b1, 32'h500}));
    end

    // Reset while a drain is in flight.
    mem_hold = 1;
    do_req(1, 32'h700, {4{32'hf0f0_0007}}, 0, k, st);
    k = 0;
    while (!(mem_valid && mem_write) && k < 50) begin
      @(negedge CLK);
      k++;
    end
    @(posedge CLK);
    #3;
    RST = 1;
    #1;
    chk("t1_mem_valid", 128'(mem_valid), 128'(0));
    chk("t1_wb_empty", 128'(wb_empty), 128'(1));
    @(posedge CLK);
    #1;
    RST = 0;
    arch.delete();
    foreach (mem_m[b]) arch[b] = mem_m[b];
    mem_hold = 0;
    m0 = mv_cnt;
    repeat (20) @(posedge CLK);
    chk("t1_no_later_write", 128'(mv_cnt - m0), 128'(0));

    // Random traffic on a small set of blocks.
    max_lat = 3;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [127:0] d;
      bit w;
      if (i % 16 == 0) mem_hold = 1;
      w = 1'($urandom_range(0, 1));
      a = (32'($urandom_range(16, 23)) << 4) | 32'($urandom_range(0, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      do_req(w, a, d, 30, k, st);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
    mem_hold = 0;
    wait_empty();
    for (int b = 16; b < 24; b++)
      chk("final_mem", mval(28'(b)), aval(28'(b)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
